// File: rtl/tetris_pkg.sv
// tetris_pkg: shared FSM states, shape ROM and spawn placement for the matrix game
package tetris_pkg;
  typedef enum logic [2:0] {SPAWN, FALL, LAND, CLEAR, GAMEOVER} state_e;
  // {top,bottom} nibbles; index 0..3 = O, I, L, T
  localparam logic [3:0][7:0] SHAPES = {8'h27, 8'h17, 8'h0F, 8'h33};
  function automatic int spawn_off(input int cols);
    return cols / 2 - 2;
  endfunction
endpackage

// File: rtl/matrix_scan_driver.sv
// matrix_scan_driver: row-multiplexed scanout with registered active-low column data
module matrix_scan_driver #(
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int SCAN_DIV = 8192
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ROWS-1:0][COLS-1:0]    frame,
  output logic [COLS-1:0]              segout,
  output logic [$clog2(ROWS)-1:0]      scanout
);
  localparam int RW = $clog2(ROWS);
  localparam int SW = $clog2(SCAN_DIV + 1);
  logic [SW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] scan_q, scan_d;
  logic [COLS-1:0] seg_q, seg_d;
  logic pulse;
  always_comb begin
    pulse  = cnt_q == SW'(SCAN_DIV - 1);
    cnt_d  = pulse ? '0 : cnt_q + 1'b1;
    scan_d = pulse ? (scan_q == RW'(ROWS - 1) ? '0 : scan_q + 1'b1) : scan_q;
    seg_d  = ~frame[scan_q];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      scan_q <= '0;
      seg_q  <= '1;
    end else begin
      cnt_q  <= cnt_d;
      scan_q <= scan_d;
      seg_q  <= seg_d;
    end
  end
  assign segout  = seg_q;
  assign scanout = scan_q;
endmodule

// File: rtl/tetris_matrix_engine.sv
// tetris_matrix_engine: falling-block game (spawn, gravity, moves, landing, line clear) on a scanned LED matrix
module tetris_matrix_engine import tetris_pkg::*; #(
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int TICK_DIV = 6250000,
  parameter int FAST_DIV = 625000,
  parameter int SCAN_DIV = 8192
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    move_left,
  input  logic                    move_right,
  input  logic                    drop_fast,
  input  logic [1:0]              next_piece,
  output logic [COLS-1:0]         segout,
  output logic [$clog2(ROWS)-1:0] scanout,
  output logic [7:0]              lines_cleared,
  output logic                    game_over
);
  localparam int RW = $clog2(ROWS);
  localparam int TW = $clog2((TICK_DIV > FAST_DIV ? TICK_DIV : FAST_DIV) + 1);
  localparam logic [RW-1:0] LAST = RW'(ROWS - 1);
  state_e state_q, state_d;
  logic [RW-1:0] prow_q, prow_d, r_q, r_d;
  logic [COLS-1:0] top_q, top_d, bot_q, bot_d, spawn_top, spawn_bot, mv_top, mv_bot;
  logic [COLS-1:0] stack_q [ROWS];
  logic [COLS-1:0] stack_d [ROWS];
  logic [7:0] lines_q, lines_d, shp;
  logic [TW-1:0] tmr_q, tmr_d, div_m1;
  logic pl_q, pr_q, pf_q, go_q;
  logic ml, mr, fchg, tick, land, mv_out, mv_hit;
  logic [ROWS-1:0][COLS-1:0] frame;
  always_comb begin
    shp       = SHAPES[next_piece];
    spawn_top = COLS'(shp[7:4]) << spawn_off(COLS);
    spawn_bot = COLS'(shp[3:0]) << spawn_off(COLS);
    ml        = move_left & ~pl_q;
    mr        = move_right & ~pr_q;
    fchg      = drop_fast ^ pf_q;
    div_m1    = drop_fast ? TW'(FAST_DIV - 1) : TW'(TICK_DIV - 1);
    tick      = state_q == FALL && !fchg && tmr_q == div_m1;
    land      = prow_q == LAST || |(bot_q & stack_q[prow_q + 1'b1]) || |(top_q & stack_q[prow_q]);
    mv_top    = ml ? top_q << 1 : top_q >> 1;
    mv_bot    = ml ? bot_q << 1 : bot_q >> 1;
    mv_out    = ml ? top_q[COLS-1] | bot_q[COLS-1] : top_q[0] | bot_q[0];
    mv_hit    = |(mv_bot & stack_q[prow_q]) || |(mv_top & stack_q[prow_q - 1'b1]);
    tmr_d     = (state_q != FALL || fchg || tick) ? '0 : tmr_q + 1'b1;
    state_d   = state_q;
    prow_d    = prow_q;
    top_d     = top_q;
    bot_d     = bot_q;
    r_d       = r_q;
    lines_d   = lines_q;
    stack_d   = stack_q;
    case (state_q)
      SPAWN: begin
        top_d   = spawn_top;
        bot_d   = spawn_bot;
        prow_d  = RW'(1);
        state_d = (|(spawn_bot & stack_q[1]) || |(spawn_top & stack_q[0])) ? GAMEOVER : FALL;
      end
      FALL:
        if (tick) begin
          state_d = land ? LAND : FALL;
          prow_d  = land ? prow_q : prow_q + 1'b1;
        end else if ((ml ^ mr) && !mv_out && !mv_hit) begin
          top_d = mv_top;
          bot_d = mv_bot;
        end
      LAND: begin
        stack_d[prow_q]        = stack_q[prow_q] | bot_q;
        stack_d[prow_q - 1'b1] = stack_q[prow_q - 1'b1] | top_q;
        r_d                    = LAST;
        state_d                = CLEAR;
      end
      CLEAR:
        if (&stack_q[r_q]) begin
          for (int i = 1; i < ROWS; i++)
            if (RW'(i) <= r_q) stack_d[i] = stack_q[i-1];
          stack_d[0] = '0;
          lines_d    = lines_q + {7'd0, lines_q != 8'hFF};
        end else begin
          r_d     = r_q - 1'b1;
          state_d = r_q == '0 ? SPAWN : CLEAR;
        end
      default: ;
    endcase
  end
  // the falling piece is overlaid on the stack only while it is actually falling
  always_comb begin
    for (int i = 0; i < ROWS; i++)
      frame[i] = stack_q[i]
               | ((state_q == FALL && RW'(i) == prow_q) ? bot_q : '0)
               | ((state_q == FALL && RW'(i) == prow_q - 1'b1) ? top_q : '0);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SPAWN;
      prow_q  <= RW'(1);
      r_q     <= '0;
      top_q   <= '0;
      bot_q   <= '0;
      lines_q <= '0;
      tmr_q   <= '0;
      stack_q <= '{default: '0};
      pl_q    <= 1'b1;
      pr_q    <= 1'b1;
      pf_q    <= drop_fast;
      go_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      prow_q  <= prow_d;
      r_q     <= r_d;
      top_q   <= top_d;
      bot_q   <= bot_d;
      lines_q <= lines_d;
      tmr_q   <= tmr_d;
      stack_q <= stack_d;
      pl_q    <= move_left;
      pr_q    <= move_right;
      pf_q    <= drop_fast;
      go_q    <= state_d == GAMEOVER;
    end
  end
  matrix_scan_driver #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV)) u_scan (
    .clk(clk), .reset(reset), .frame(frame), .segout(segout), .scanout(scanout)
  );
  assign lines_cleared = lines_q;
  assign game_over     = go_q;
endmodule

// File: tb/tb_tetris_matrix_engine.sv
// tb_tetris_matrix_engine: directed game scenarios plus random play against a cell-level game model
module tb_tetris_matrix_engine;
  localparam int ROWS = 8, COLS = 8, TICK_DIV = 4, FAST_DIV = 2, SCAN_DIV = 2;
  localparam int P_SPAWN = 0, P_FALL = 1, P_LAND = 2, P_CLEAR = 3, P_OVER = 4;
  logic clk = 0, reset, move_left, move_right, drop_fast;
  logic [1:0] next_piece;
  logic [7:0] segout, lines_cleared;
  logic [2:0] scanout;
  logic game_over;
  always #5 clk = ~clk;
  tetris_matrix_engine #(.ROWS(ROWS), .COLS(COLS), .TICK_DIV(TICK_DIV), .FAST_DIV(FAST_DIV),
    .SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .reset(reset), .move_left(move_left), .move_right(move_right),
    .drop_fast(drop_fast), .next_piece(next_piece), .segout(segout), .scanout(scanout),
    .lines_cleared(lines_cleared), .game_over(game_over));
  int checks = 0, errors = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // game model: piece is a shape index plus a column offset; cells are placed bit by bit
  int tops[4] = '{3, 0, 1, 2};
  int bots[4] = '{3, 15, 7, 7};
  int stk[ROWS];
  int ph, psh, prow, pcol, rr, lines, tcnt, m_sc, m_row, m_seg;
  bit pl, pr, pf;
  function automatic int place(input int n, input int col);
    int b = 0;
    for (int i = 0; i < 4; i++)
      if (n[i]) begin
        if (col + i < 0 || col + i >= COLS) return -1;
        b |= 1 << (col + i);
      end
    return b;
  endfunction
  function automatic bit fits(input int shp, input int row, input int col);
    int t = place(tops[shp], col);
    int b = place(bots[shp], col);
    if (t < 0 || b < 0 || row >= ROWS) return 0;
    return (b & stk[row]) == 0 && (t & stk[row-1]) == 0;
  endfunction
  function automatic int frame_row(input int i);
    int v = stk[i];
    if (ph == P_FALL) begin
      if (i == prow) v |= place(bots[psh], pcol);
      if (i == prow - 1) v |= place(tops[psh], pcol);
    end
    return v;
  endfunction
  task automatic model_step();
    int nseg, d;
    bit el, er, fchg, tk;
    nseg = ~frame_row(m_row) & 8'hFF;
    if (reset) begin
      foreach (stk[i]) stk[i] = 0;
      ph = P_SPAWN; lines = 0; tcnt = 0; m_sc = 0; m_row = 0; m_seg = 8'hFF;
      pl = 1; pr = 1; pf = drop_fast;
      return;
    end
    m_seg = nseg;
    if (m_sc == SCAN_DIV - 1) begin m_sc = 0; m_row = (m_row + 1) % ROWS; end
    else m_sc++;
    el = move_left && !pl; er = move_right && !pr;
    pl = move_left; pr = move_right;
    fchg = drop_fast != pf; pf = drop_fast;
    tk = 0;
    if (ph == P_FALL) begin
      tk = !fchg && tcnt == (drop_fast ? FAST_DIV : TICK_DIV) - 1;
      tcnt = (fchg || tk) ? 0 : tcnt + 1;
    end else tcnt = 0;
    case (ph)
      P_SPAWN: begin
        psh = int'(next_piece); prow = 1; pcol = COLS / 2 - 2;
        ph = fits(psh, 1, pcol) ? P_FALL : P_OVER;
      end
      P_FALL:
        if (tk) begin
          if (fits(psh, prow + 1, pcol)) prow++;
          else ph = P_LAND;
        end else if (el != er) begin
          d = el ? 1 : -1;
          if (fits(psh, prow, pcol + d)) pcol += d;
        end
      P_LAND: begin
        stk[prow] |= place(bots[psh], pcol);
        stk[prow-1] |= place(tops[psh], pcol);
        rr = ROWS - 1; ph = P_CLEAR;
      end
      P_CLEAR:
        if (stk[rr] == (1 << COLS) - 1) begin
          for (int i = rr; i > 0; i--) stk[i] = stk[i-1];
          stk[0] = 0;
          if (lines < 255) lines++;
        end else if (rr == 0) ph = P_SPAWN;
        else rr--;
      default: ;
    endcase
  endtask
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("segout", segout, m_seg);
    check("scanout", scanout, m_row);
    check("lines_cleared", lines_cleared, lines);
    check("game_over", game_over, ph == P_OVER);
  endtask
  task automatic do_reset();
    reset = 1; cyc(); reset = 0;
  endtask
  task automatic wait_ph(input int p, input int lim);
    int n = 0;
    while (ph != p && n < lim) begin cyc(); n++; end
    check("phase_timeout", n < lim, 1);
  endtask
  task automatic press(input bit right, input bit at_tick);
    int n = 0;
    while (!(ph == P_FALL && (at_tick ? tcnt == TICK_DIV - 1 : tcnt <= TICK_DIV - 3)) && n < 50) begin
      cyc(); n++;
    end
    check("press_timeout", n < 50, 1);
    if (right) move_right = 1; else move_left = 1;
    cyc();
    move_right = 0; move_left = 0;
    cyc();
  endtask
  task automatic read_row(input int k, output logic [7:0] v);
    int n = 0;
    while (scanout !== 3'(k) && n < 40) begin cyc(); n++; end
    check("scan_timeout", n < 40, 1);
    cyc();
    v = segout;
  endtask
  logic [7:0] v;
  initial begin
    move_left = 0; move_right = 0; drop_fast = 0; next_piece = 0;
    do_reset();
    check("rst_segout", segout, 8'hFF);
    check("rst_scanout", scanout, 0);
    check("rst_lines", lines_cleared, 0);
    check("rst_game_over", game_over, 0);
    for (int k = 1; k <= 17; k++) begin
      cyc();
      check("scan_step", scanout, (k / 2) % 8);
    end
    // O piece lands at the bottom
    do_reset();
    wait_ph(P_CLEAR, 100);
    wait_ph(P_FALL, 20);
    read_row(6, v); check("land_row6", v, 8'hF3);
    read_row(7, v); check("land_row7", v, 8'hF3);
    // I piece pushed hard right, then a move on a gravity step
    do_reset(); next_piece = 1;
    wait_ph(P_FALL, 10);
    for (int i = 0; i < 7; i++) press(1, 0);
    press(0, 1);
    wait_ph(P_CLEAR, 100);
    read_row(7, v); check("move_row7", v, 8'hF0);
    // two I pieces fill the bottom row
    do_reset(); next_piece = 1;
    wait_ph(P_FALL, 10);
    press(1, 0); press(1, 0);
    wait_ph(P_SPAWN, 100);
    wait_ph(P_FALL, 10);
    press(0, 0); press(0, 0);
    wait_ph(P_SPAWN, 100);
    check("clear_lines", lines_cleared, 1);
    read_row(7, v); check("clear_row7", v, 8'hFF);
    // stack O pieces until spawn collides
    do_reset(); next_piece = 0;
    wait_ph(P_OVER, 400);
    check("over_flag", game_over, 1);
    for (int i = 0; i < 20; i++) begin
      move_left = i[1]; move_right = i[2]; drop_fast = i[3];
      cyc();
    end
    move_left = 0; move_right = 0; drop_fast = 0;
    read_row(0, v); check("over_row0", v, 8'hF3);
    do_reset();
    check("rst2_segout", segout, 8'hFF);
    check("rst2_scanout", scanout, 0);
    check("rst2_lines", lines_cleared, 0);
    check("rst2_game_over", game_over, 0);
    // fast drop, then release mid-fall
    drop_fast = 1; do_reset();
    wait_ph(P_LAND, 60);
    wait_ph(P_FALL, 20);
    for (int i = 0; i < 5; i++) cyc();
    drop_fast = 0;
    for (int i = 0; i < 30; i++) cyc();
    // random play
    for (int i = 0; i < 3000; i++) begin
      if ($urandom % 6 == 0) move_left = ~move_left;
      if ($urandom % 6 == 0) move_right = ~move_right;
      if ($urandom % 40 == 0) drop_fast = ~drop_fast;
      next_piece = 2'($urandom % 4);
      if ((ph == P_OVER && $urandom % 30 == 0) || $urandom % 700 == 0) do_reset();
      else cyc();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
